// File: rtl/data_sram_responder.sv
// data_sram_responder: responder side of the SRAM-like data interface.
// Requests are queued in an in-order FIFO and served one at a time against a
// synchronous single-port RAM (1-cycle read latency), with optional wait states.
//
// Handshake: a request transfers in any cycle where data_req && data_addr_ok.
// data_addr_ok is derived from registered state only (never from data_req), so
// a pop in the same cycle does not open a slot. Every transfer produces exactly
// one data_data_ok pulse, in acceptance order. data_rdata is valid during that
// pulse for loads.
module data_sram_responder #(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [3:0]    WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [29:0] addr;
    logic [31:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  entry_t          fifo_q [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  state_t          state;
  logic [3:0]      wait_cnt;
  logic            resp_wr;
  logic [31:0]     rdata_q;
  entry_t          head;
  logic            push;
  logic            pop;
  logic            start;
  logic            unused_inputs;

  // Size and the byte offset are carried by the protocol but not needed here.
  assign unused_inputs = ^{data_size, data_addr[1:0]};

  assign head         = fifo_q[rd_ptr];
  assign data_addr_ok = resetn && (count < DEPTH_C);
  assign push         = data_req && data_addr_ok;
  assign pop          = (state == S_ACCESS);
  // Count as it will be after this cycle; lets a push in IDLE/RESP start service next cycle.
  assign count_next   = count + CW'(push) - CW'(pop);
  assign start        = (count_next != '0);

  // Outputs decode the registered state; everything is forced low during reset.
  assign ram_en       = resetn && (state == S_ACCESS);
  assign ram_wen      = (ram_en && head.wr) ? head.wstrb : 4'b0000;
  assign ram_addr     = ram_en ? {head.addr, 2'b00} : 32'h0;
  assign ram_wdata    = ram_en ? head.wdata : 32'h0;
  assign data_data_ok = resetn && (state == S_RESP);
  assign data_rdata   = !resetn ? 32'h0
                      : ((state == S_RESP) && !resp_wr) ? ram_rdata
                      : rdata_q;

  // FIFO storage: capture the request fields only in the accept cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{wr: data_wr, wstrb: data_wstrb,
                          addr: data_addr[31:2], wdata: data_wdata};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // Service FSM: optional wait states, one RAM access, one response cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      resp_wr  <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (LATENCY > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_ACCESS;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_ACCESS: begin
          resp_wr <= head.wr;
          state   <= S_RESP;
        end
        S_RESP: begin
          if (!resp_wr) rdata_q <= ram_rdata;
          if (start) begin
            if (LATENCY > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= S_ACCESS;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one LATENCY=0 instance for the main
// behaviour and one LATENCY=3 instance for wait states, each with its own RAM.
module tb_data_sram_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  // ---------------- LATENCY=0 instance ----------------
  logic        req, wr;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic [2:0]  size;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  data_sram_responder #(.DEPTH(2), .LATENCY(0)) dut (
    .clk(clk), .resetn(resetn),
    .data_req(req), .data_wr(wr), .data_wstrb(wstrb), .data_addr(addr),
    .data_size(size), .data_wdata(wdata),
    .data_addr_ok(addr_ok), .data_data_ok(data_ok), .data_rdata(rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // ---------------- LATENCY=3 instance ----------------
  logic        w_req, w_wr;
  logic [3:0]  w_wstrb;
  logic [31:0] w_addr, w_wdata;
  logic [2:0]  w_size;
  logic        w_addr_ok, w_data_ok;
  logic [31:0] w_rdata;
  logic        w_ram_en;
  logic [3:0]  w_ram_wen;
  logic [31:0] w_ram_addr, w_ram_wdata, w_ram_rdata;

  data_sram_responder #(.DEPTH(2), .LATENCY(3)) dut_w (
    .clk(clk), .resetn(resetn),
    .data_req(w_req), .data_wr(w_wr), .data_wstrb(w_wstrb), .data_addr(w_addr),
    .data_size(w_size), .data_wdata(w_wdata),
    .data_addr_ok(w_addr_ok), .data_data_ok(w_data_ok), .data_rdata(w_rdata),
    .ram_en(w_ram_en), .ram_wen(w_ram_wen), .ram_addr(w_ram_addr),
    .ram_wdata(w_ram_wdata), .ram_rdata(w_ram_rdata)
  );

  // ---------------- RAM models (1-cycle read latency, byte writes) ----------------
  logic [31:0] mem   [256];
  logic [31:0] mem_w [256];
  logic        pre_en, pre_sel;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_en && !pre_sel) mem[pre_idx]   <= pre_val;
    if (pre_en &&  pre_sel) mem_w[pre_idx] <= pre_val;
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= mem[ram_addr[9:2]];
    end
    if (w_ram_en) begin
      for (int b = 0; b < 4; b++)
        if (w_ram_wen[b]) mem_w[w_ram_addr[9:2]][b*8 +: 8] <= w_ram_wdata[b*8 +: 8];
      w_ram_rdata <= mem_w[w_ram_addr[9:2]];
    end
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic preload(input logic sel, input logic [31:0] a, input logic [31:0] v);
    pre_en  = 1'b1;
    pre_sel = sel;
    pre_idx = a[9:2];
    pre_val = v;
    next_cycle();
    pre_en  = 1'b0;
  endtask

  // Backpressure expectations, one entry per cycle.
  logic bp_aok [10] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 1};
  logic bp_dok [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0;
    req = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; size = 3'b010;
    w_req = 1'b0; w_wr = 1'b0; w_wstrb = 4'h0; w_addr = 32'h0; w_wdata = 32'h0; w_size = 3'b010;
    pre_en = 1'b0; pre_sel = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;

    next_cycle();
    preload(1'b0, 32'h100, 32'hDEADBEEF);
    preload(1'b0, 32'h104, 32'h11223344);
    preload(1'b0, 32'h110, 32'hA0A00000);
    preload(1'b0, 32'h114, 32'hA0A00001);
    preload(1'b0, 32'h118, 32'hA0A00002);
    preload(1'b0, 32'h11C, 32'hA0A00003);
    preload(1'b0, 32'h120, 32'h55667788);
    preload(1'b1, 32'h200, 32'hCAFEF00D);

    // Reset state
    mid();
    check_bit("rst_addr_ok", addr_ok, 1'b0);
    check_bit("rst_data_ok", data_ok, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check_bit("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check_bit("rst_w_addr_ok", w_addr_ok, 1'b0);

    next_cycle(); resetn = 1'b1;
    mid();
    check_bit("rel_addr_ok", addr_ok, 1'b1);
    check_bit("rel_w_addr_ok", w_addr_ok, 1'b1);

    // Single load, low address bits ignored
    next_cycle(); req = 1'b1; wr = 1'b0; wstrb = 4'hF; addr = 32'h102;
    mid();
    check_bit("ld_aok", addr_ok, 1'b1);
    check_bit("ld_ram_en_T", ram_en, 1'b0);
    next_cycle(); req = 1'b0; addr = 32'h0; wstrb = 4'h0;
    mid();
    check_bit("ld_ram_en", ram_en, 1'b1);
    check("ld_ram_addr", ram_addr, 32'h100);
    check("ld_ram_wen", 32'(ram_wen), 32'h0);
    check_bit("ld_dok_T1", data_ok, 1'b0);
    next_cycle();
    mid();
    check_bit("ld_dok", data_ok, 1'b1);
    check("ld_rdata", rdata, 32'hDEADBEEF);
    next_cycle();
    mid();
    check_bit("ld_dok_after", data_ok, 1'b0);
    check("ld_rdata_hold", rdata, 32'hDEADBEEF);
    check_bit("ld_ram_en_after", ram_en, 1'b0);

    // Byte store then load to the same word
    next_cycle(); req = 1'b1; wr = 1'b1; wstrb = 4'b0100; addr = 32'h104; wdata = 32'h00AB0000;
    mid();
    check_bit("st_aok", addr_ok, 1'b1);
    next_cycle(); wr = 1'b0; wstrb = 4'b0000; wdata = 32'h0; addr = 32'h104;
    mid();
    check_bit("st_ld_aok", addr_ok, 1'b1);
    check_bit("st_ram_en", ram_en, 1'b1);
    check("st_ram_wen", 32'(ram_wen), 32'h4);
    check("st_ram_addr", ram_addr, 32'h104);
    check("st_ram_wdata", ram_wdata, 32'h00AB0000);
    next_cycle(); req = 1'b0;
    mid();
    check_bit("st_dok", data_ok, 1'b1);
    check("st_rdata_hold", rdata, 32'hDEADBEEF);
    check_bit("st_ram_en_resp", ram_en, 1'b0);
    next_cycle();
    mid();
    check_bit("st_ld_ram_en", ram_en, 1'b1);
    check("st_ld_ram_wen", 32'(ram_wen), 32'h0);
    check("st_ld_ram_addr", ram_addr, 32'h104);
    check_bit("st_ld_dok_acc", data_ok, 1'b0);
    next_cycle();
    mid();
    check_bit("st_ld_dok", data_ok, 1'b1);
    check("st_ld_rdata", rdata, 32'h11AB3344);
    next_cycle();
    mid();
    check_bit("st_ld_dok_after", data_ok, 1'b0);

    // Backpressure: data_req held high for four loads
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      req  = (c < 5);
      wr   = 1'b0;
      addr = 32'h110 + 32'(4 * ((c < 3) ? c : 3));
      mid();
      check_bit($sformatf("bp_aok_c%0d", c), addr_ok, bp_aok[c]);
      check_bit($sformatf("bp_dok_c%0d", c), data_ok, bp_dok[c]);
      if (bp_dok[c])
        check($sformatf("bp_rdata_c%0d", c), rdata, 32'hA0A00000 + 32'(c / 2 - 1));
    end
    req = 1'b0;

    // Wait states on the LATENCY=3 instance
    next_cycle(); w_req = 1'b1; w_wr = 1'b0; w_addr = 32'h200;
    mid();
    check_bit("ws_aok", w_addr_ok, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); w_req = 1'b0;
      mid();
      check_bit($sformatf("ws_ram_en_c%0d", c), w_ram_en, (c == 4));
      check_bit($sformatf("ws_dok_c%0d", c), w_data_ok, (c == 5));
      if (c == 4) check("ws_ram_addr", w_ram_addr, 32'h200);
      if (c == 5) check("ws_rdata", w_rdata, 32'hCAFEF00D);
    end

    // Reset during the first access of two queued requests
    next_cycle(); req = 1'b1; wr = 1'b0; addr = 32'h100;
    mid();
    check_bit("rm_aok0", addr_ok, 1'b1);
    next_cycle(); addr = 32'h104;
    mid();
    check_bit("rm_aok1", addr_ok, 1'b1);
    next_cycle(); addr = 32'h110;
    mid();
    check_bit("rm_aok2", addr_ok, 1'b1);
    check_bit("rm_dok_x", data_ok, 1'b1);
    next_cycle(); req = 1'b0; resetn = 1'b0;
    mid();
    check_bit("rm_rst_ram_en", ram_en, 1'b0);
    check_bit("rm_rst_dok", data_ok, 1'b0);
    check_bit("rm_rst_aok", addr_ok, 1'b0);
    check("rm_rst_rdata", rdata, 32'h0);
    next_cycle(); resetn = 1'b1;
    mid();
    check_bit("rm_rel_aok", addr_ok, 1'b1);
    check_bit("rm_rel_dok", data_ok, 1'b0);
    check("rm_rel_rdata", rdata, 32'h0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      mid();
      check_bit($sformatf("rm_quiet_dok_c%0d", c), data_ok, 1'b0);
      check_bit($sformatf("rm_quiet_en_c%0d", c), ram_en, 1'b0);
    end
    next_cycle(); req = 1'b1; addr = 32'h100;
    mid();
    check_bit("rm_new_aok", addr_ok, 1'b1);
    next_cycle(); req = 1'b0;
    mid();
    check_bit("rm_new_ram_en", ram_en, 1'b1);
    next_cycle();
    mid();
    check_bit("rm_new_dok", data_ok, 1'b1);
    check("rm_new_rdata", rdata, 32'hDEADBEEF);

    // Store with no byte enables
    next_cycle(); req = 1'b1; wr = 1'b1; wstrb = 4'b0000; addr = 32'h120; wdata = 32'hFFFFFFFF;
    mid();
    check_bit("z_aok", addr_ok, 1'b1);
    next_cycle(); req = 1'b0; wr = 1'b0; wdata = 32'h0;
    mid();
    check_bit("z_ram_en", ram_en, 1'b1);
    check("z_ram_wen", 32'(ram_wen), 32'h0);
    check("z_ram_addr", ram_addr, 32'h120);
    next_cycle();
    mid();
    check_bit("z_dok", data_ok, 1'b1);
    check("z_rdata_hold", rdata, 32'hDEADBEEF);
    next_cycle();
    mid();
    check_bit("z_dok_after", data_ok, 1'b0);
    check("z_mem_unchanged", mem[8'h48], 32'h55667788);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
